// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : Byte-oriented SPI master, MSB first, sck idle low, active-high ss.
//            Optional self-test loopback enabled by SPI_MASTER_LOOPBACK_EN.
// Revision : 1.0
// ============================================================================
module spi_master #(
    parameter int  CLKDIV  = 4,
    parameter int  NSLAVES = 4,
    localparam int SEL_W   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    input  logic [7:0]         tx_data_i,
    input  logic [SEL_W-1:0]   tx_sel_i,
    input  logic               tx_last_i,
    output logic [7:0]         rx_data_o,
    output logic               rx_valid_o,
    output logic               sck_o,
    output logic               mosi_o,
    input  logic               miso_i,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic               loopback_i,
`endif
    output logic [NSLAVES-1:0] ss_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    localparam logic [7:0] C_DIV_LAST = 8'(CLKDIV - 1);

    state_t           state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             last_q, last_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic w_loopback;
    logic w_div_last;
    logic w_handshake;
    logic w_sample;
    logic w_ss_active;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_loopback = loopback_i;
`else
    assign w_loopback = 1'b0;
`endif

    assign w_div_last  = (div_cnt_q == C_DIV_LAST);
    assign w_handshake = tx_valid_i && tx_ready_o;
    assign w_sample    = w_loopback ? mosi_o : miso_i;

    // The WAIT entry cycle carries the rx strobe; ready is withheld there so
    // a strobe and an accepted request never share a cycle.
    assign tx_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && !rx_valid_q);
    assign sck_o       = (state_q == ST_HIGH);
    assign mosi_o      = ((state_q == ST_IDLE) || (state_q == ST_GAP)) ? 1'b0 : tx_sr_q[7];
    assign w_ss_active = !w_loopback &&
                         ((state_q == ST_SETUP) || (state_q == ST_LOW) ||
                          (state_q == ST_HIGH)  || (state_q == ST_WAIT) ||
                          (state_q == ST_HOLD));
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;

    // Out-of-range selects match no index, so the bus stays deselected.
    for (genvar i = 0; i < NSLAVES; i++) begin : g_ss
        assign ss_o[i] = w_ss_active && (sel_q == SEL_W'(i));
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = 8'd0;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sel_d      = sel_q;
        last_d     = last_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if ((state_q != ST_IDLE) && (state_q != ST_WAIT)) begin
            div_cnt_d = w_div_last ? 8'd0 : div_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_handshake) begin
                    tx_sr_d = tx_data_i;
                    sel_d   = tx_sel_i;
                    last_d  = tx_last_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: if (w_div_last) state_d = ST_LOW;
            ST_LOW:   if (w_div_last) state_d = ST_HIGH;
            ST_HIGH: begin
                if (w_div_last) begin
                    rx_sr_d = {rx_sr_q[6:0], w_sample};
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_sr_q[6:0], w_sample};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                        state_d    = last_q ? ST_HOLD : ST_WAIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = ST_LOW;
                    end
                end
            end
            ST_WAIT: begin
                if (w_handshake) begin
                    tx_sr_d = tx_data_i;
                    last_d  = tx_last_i;
                    state_d = ST_LOW;
                end
            end
            ST_HOLD: if (w_div_last) state_d = ST_GAP;
            ST_GAP:  if (w_div_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_sr_q    <= 8'd0;
            rx_sr_q    <= 8'd0;
            sel_q      <= '0;
            last_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule
`default_nettype wire
